// File: rtl/duty_modulator.sv
// duty_modulator: symbol-driven duty-cycle modulator with kick and level phases.
// Optional slew limiting of the duty output is compiled in with `define DUTY_SLEW_EN.
module duty_modulator #(
    parameter int DW        = 12,
    parameter int CW        = 20,
    parameter int DMAX      = 500,
    parameter int SLEW_STEP = 16
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_alive,
    input  logic [1:0]    i_mode,
    input  logic [DW-1:0] i_base_duty,
    input  logic [CW-1:0] i_hold_len,
    input  logic [CW-1:0] i_sym_len,
    input  logic          i_sym_valid,
    input  logic          i_sym_data,
    output logic          o_sym_ready,
    output logic [DW-1:0] o_duty,
    output logic          o_busy
);
`ifdef DUTY_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif
    localparam logic [DW-1:0] DMAX_D = DW'(DMAX);
    localparam logic [DW+1:0] DMAX_X = (DW+2)'(DMAX);
    // an all-ones step never limits, so the output lands on the target every cycle
    localparam logic [DW-1:0] STEP_D = SLEW_ON ? DW'(SLEW_STEP) : '1;

    typedef enum logic [1:0] {IDLE, KICK, LEVEL} state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_data;
    logic [DW-1:0] r_level;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] r_sym_cnt;
    logic [DW-1:0] r_duty;

    logic          w_en;
    logic          w_accept;
    logic [DW-1:0] w_base_clamp;
    logic [DW+1:0] w_bx;
    logic [DW+1:0] w_h1;
    logic [DW+1:0] w_h2;
    logic [DW+1:0] w_hi;
    logic [DW+1:0] w_lo;
    logic [DW+1:0] w_lvl_x;
    logic [DW-1:0] w_level;
    logic [DW-1:0] w_target;
    logic [DW-1:0] w_duty_next;

    assign w_en         = (i_mode == 2'b11) && i_alive;
    assign o_sym_ready  = (r_state == IDLE) && w_en && i_nrst;
    assign w_accept     = i_sym_valid && o_sym_ready;
    assign w_base_clamp = (i_base_duty > DMAX_D) ? DMAX_D : i_base_duty;
    assign o_duty       = r_duty;
    assign o_busy       = r_busy;

    // level for the offered symbol, in widened arithmetic so b+b/2 cannot overflow
    always_comb begin
        w_bx    = {2'b00, w_base_clamp};
        w_h1    = w_bx + (w_bx >> 1);
        w_h2    = w_bx + (w_bx >> 2);
        w_lo    = w_bx / (DW+2)'(3);
        w_hi    = (w_h1 < DMAX_X) ? w_h1 : (w_h2 < DMAX_X) ? w_h2 : DMAX_X;
        w_lvl_x = i_sym_data ? w_hi : w_lo;
        w_level = (w_lvl_x > DMAX_X) ? DMAX_D : w_lvl_x[DW-1:0];
    end

    // duty target from the current phase; IDLE follows the live clamped base
    always_comb begin
        w_target = (r_state == KICK)  ? (r_data ? DMAX_D : '0) :
                   (r_state == LEVEL) ? r_level : w_base_clamp;
    end

    // move toward the target by at most STEP_D, landing exactly on it
    always_comb begin
        w_duty_next = (w_target > r_duty) ?
                      ((w_target - r_duty > STEP_D) ? r_duty + STEP_D : w_target) :
                      ((r_duty - w_target > STEP_D) ? r_duty - STEP_D : w_target);
    end

    // phase sequencing: accept, kick countdown, level countdown, abort on link loss
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_data     <= 1'b0;
            r_level    <= '0;
            r_hold_cnt <= '0;
            r_sym_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data     <= i_sym_data;
                        r_level    <= w_level;
                        r_busy     <= 1'b1;
                        r_sym_cnt  <= (i_sym_len == '0) ? CW'(1) : i_sym_len;
                        r_hold_cnt <= i_hold_len;
                        r_state    <= (i_hold_len != '0) ? KICK : LEVEL;
                    end
                end
                KICK: begin
                    if (!w_en) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                        r_sym_cnt  <= '0;
                    end else if (r_hold_cnt <= CW'(1)) begin
                        r_state    <= LEVEL;
                        r_hold_cnt <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - CW'(1);
                    end
                end
                LEVEL: begin
                    if (!w_en || r_sym_cnt <= CW'(1)) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_hold_cnt <= '0;
                        r_sym_cnt  <= '0;
                    end else begin
                        r_sym_cnt  <= r_sym_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // registered duty command; reset loads the clamped base directly
    always_ff @(posedge i_clk) begin
        if (!i_nrst) r_duty <= w_base_clamp;
        else         r_duty <= w_duty_next;
    end
endmodule

// File: tb/tb_duty_modulator.sv
// tb_duty_modulator: directed self-checking bench for duty_modulator (default build).
module tb_duty_modulator;
    logic        clk = 1'b0;
    logic        nrst;
    logic        alive;
    logic [1:0]  mode;
    logic [11:0] base_duty;
    logic [19:0] hold_len;
    logic [19:0] sym_len;
    logic        sym_valid;
    logic        sym_data;
    logic        sym_ready;
    logic [11:0] duty;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    duty_modulator dut (
        .i_clk(clk), .i_nrst(nrst), .i_alive(alive), .i_mode(mode),
        .i_base_duty(base_duty), .i_hold_len(hold_len), .i_sym_len(sym_len),
        .i_sym_valid(sym_valid), .i_sym_data(sym_data),
        .o_sym_ready(sym_ready), .o_duty(duty), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        nrst = 1'b0; alive = 1'b1; mode = 2'b11; base_duty = 12'd200;
        hold_len = '0; sym_len = '0; sym_valid = 1'b0; sym_data = 1'b0;
        tick();
        check("rst_duty", duty, 200);
        check("rst_busy", busy, 0);
        check("rst_ready", sym_ready, 0);
        nrst = 1'b1; #1;
        check("idle_ready", sym_ready, 1);

        // base=200 hold=3 sym=5 data=1
        hold_len = 3; sym_len = 5; sym_data = 1'b1; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        check("a_acc_busy", busy, 1);
        check("a_acc_ready", sym_ready, 0);
        check("a_acc_duty", duty, 200);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("a_duty_%0d", i), duty, i <= 3 ? 500 : i <= 8 ? 300 : 200);
            check($sformatf("a_busy_%0d", i), busy, i <= 7 ? 1 : 0);
        end

        // base=400 hold=0 sym=2 data=1: no kick, level saturates at 500
        base_duty = 12'd400; hold_len = 0; sym_len = 2; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        check("b_acc_duty", duty, 400);
        check("b_acc_busy", busy, 1);
        tick(); check("b_duty_1", duty, 500); check("b_busy_1", busy, 1);
        tick(); check("b_duty_2", duty, 500); check("b_busy_2", busy, 0);
        tick(); check("b_duty_3", duty, 400);

        // base=300 hold=0 sym=0 data=0: one level cycle at 300/3
        base_duty = 12'd300; sym_len = 0; sym_data = 1'b0; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        tick(); check("l_duty_1", duty, 100); check("l_busy_1", busy, 0);
        tick(); check("l_duty_2", duty, 300);

        // base=300 hold=2 data=0, alive dropped in second kick cycle
        hold_len = 2; sym_len = 4; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        tick();
        check("c_kick_duty", duty, 0);
        alive = 1'b0; #1;
        check("c_ready_dead", sym_ready, 0);
        tick();
        check("c_abort_busy", busy, 0);
        check("c_abort_duty", duty, 0);
        check("c_abort_ready", sym_ready, 0);
        tick();
        check("c_base_duty", duty, 300);
        check("c_ready_still", sym_ready, 0);
        alive = 1'b1; #1;
        check("c_ready_back", sym_ready, 1);

        // back-to-back with sym_valid held: base=200 hold=1 sym=2 data=1, then data=0 hold=0 sym=1
        base_duty = 12'd200; hold_len = 1; sym_len = 2; sym_data = 1'b1; sym_valid = 1'b1;
        tick();
        hold_len = 0; sym_len = 1; sym_data = 1'b0;
        tick(); check("d_duty_1", duty, 500); check("d_ready_1", sym_ready, 0); check("d_busy_1", busy, 1);
        tick(); check("d_duty_2", duty, 300); check("d_busy_2", busy, 1);
        tick(); check("d_duty_3", duty, 300); check("d_busy_3", busy, 0); check("d_ready_3", sym_ready, 1);
        tick(); check("d_acc2_busy", busy, 1); check("d_acc2_duty", duty, 200);
        sym_valid = 1'b0;
        tick(); check("d_low_duty", duty, 66); check("d_low_busy", busy, 0);
        tick(); check("d_end_duty", duty, 200);

        // mode other than 2'b11 blocks acceptance
        mode = 2'b10; sym_valid = 1'b1; #1;
        check("m_ready", sym_ready, 0);
        tick();
        check("m_busy", busy, 0);
        sym_valid = 1'b0; mode = 2'b11;

        // reset during level: base=120 hold=2 sym=10 data=1 -> level 180
        base_duty = 12'd120; hold_len = 2; sym_len = 10; sym_data = 1'b1; sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        tick(); tick(); tick();
        check("e_level_duty", duty, 180);
        check("e_level_busy", busy, 1);
        nrst = 1'b0; #1;
        check("e_rst_ready", sym_ready, 0);
        tick();
        check("e_rst_duty", duty, 120);
        check("e_rst_busy", busy, 0);
        base_duty = 12'd700;
        tick();
        check("e_rst_clamp", duty, 500);
        nrst = 1'b1;
        tick();
        check("e_idle_clamp", duty, 500);
        check("e_idle_busy", busy, 0);
        check("e_idle_ready", sym_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
